// File: rtl/phase_sequencer.sv
// Multi-phase one-hot sequencer: rotates PHI_OUT through NPH phases of DWELL+1 cycles each,
// for a latched number of rotations or until a graceful stop completes the current rotation.
module phase_sequencer #(
    parameter int NPH = 3,
    parameter int DW  = 4
) (
    input  logic          CLK_IN,
    input  logic          RST_IN,
    input  logic          START_IN,
    input  logic          STOP_IN,
    input  logic [DW-1:0] DWELL_IN,
    input  logic [7:0]    CYCLES_IN,
    output logic [NPH-1:0] PHI_OUT,
    output logic          SYNC_OUT,
    output logic          BUSY_OUT,
    output logic          DONE_OUT,
    output logic          ERR_OUT
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [NPH-1:0] PH1  = NPH'(1);
    localparam logic [DW-1:0]  ONE  = DW'(1);

    state_t         state_q, state_d;
    logic [NPH-1:0] phi_q, phi_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic [7:0]     cycles_q, cycles_d;
    logic [7:0]     rot_q, rot_d;
    logic           sync_q, sync_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [7:0]     rot_n;
    logic           last_rot;
    logic           phi_ok;
    logic           stop_now;

    always_comb begin
        state_d  = state_q;
        phi_d    = phi_q;
        dwell_d  = dwell_q;
        dcnt_d   = dcnt_q;
        cycles_d = cycles_q;
        rot_d    = rot_q;
        sync_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        rot_n    = rot_q + 8'd1;
        last_rot = (cycles_q != 8'd0) && (rot_n == cycles_q);
        phi_ok   = (phi_q != '0) && ((phi_q & (phi_q - PH1)) == '0);
        stop_now = (state_q == STOPPING) || STOP_IN;

        case (state_q)
            IDLE: begin
                phi_d  = '0;
                busy_d = 1'b0;
                if (START_IN) begin
                    state_d  = RUN;
                    dwell_d  = DWELL_IN;
                    cycles_d = CYCLES_IN;
                    dcnt_d   = DWELL_IN;
                    rot_d    = 8'd0;
                    phi_d    = PH1;
                    sync_d   = 1'b1;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                end
            end
            RUN, STOPPING: begin
                busy_d = 1'b1;
                if (state_q == RUN && STOP_IN) begin
                    state_d = STOPPING;
                end
                // A corrupted phase register restarts the rotation without counting it
                if (!phi_ok) begin
                    phi_d  = PH1;
                    dcnt_d = dwell_q;
                    err_d  = 1'b1;
                end else if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - ONE;
                end else if (phi_q[NPH-1]) begin
                    if (stop_now || last_rot) begin
                        state_d = IDLE;
                        phi_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rot_d   = rot_n;
                    end else begin
                        phi_d  = PH1;
                        sync_d = 1'b1;
                        dcnt_d = dwell_q;
                        rot_d  = rot_n;
                    end
                end else begin
                    phi_d  = {phi_q[NPH-2:0], 1'b0};
                    dcnt_d = dwell_q;
                end
            end
            default: begin
                state_d = IDLE;
                phi_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q  <= IDLE;
            phi_q    <= '0;
            dwell_q  <= '0;
            dcnt_q   <= '0;
            cycles_q <= 8'd0;
            rot_q    <= 8'd0;
            sync_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phi_q    <= phi_d;
            dwell_q  <= dwell_d;
            dcnt_q   <= dcnt_d;
            cycles_q <= cycles_d;
            rot_q    <= rot_d;
            sync_q   <= sync_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign PHI_OUT  = phi_q;
    assign SYNC_OUT = sync_q;
    assign BUSY_OUT = busy_q;
    assign DONE_OUT = done_q;
    assign ERR_OUT  = err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NPH=3, DW=4): inputs driven and outputs sampled on the
// falling edge, each scenario walked cycle by cycle against hand-derived values.
module tb_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] dwell;
    logic [7:0] cycles;
    logic [2:0] phi;
    logic       sync;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    phase_sequencer #(.NPH(3), .DW(4)) dut (
        .CLK_IN   (clk),
        .RST_IN   (rst),
        .START_IN (start),
        .STOP_IN  (stop),
        .DWELL_IN (dwell),
        .CYCLES_IN(cycles),
        .PHI_OUT  (phi),
        .SYNC_OUT (sync),
        .BUSY_OUT (busy),
        .DONE_OUT (done),
        .ERR_OUT  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] e_phi;

        rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 4'd0; cycles = 8'd0;
        step(); step();
        chk("rst_phi", 32'(phi), 32'h0);
        chk("rst_sync", 32'(sync), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // two rotations of 2-cycle phases
        dwell = 4'd1; cycles = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e_phi = 3'(1 << ((i / 2) % 3));
            chk("s1_phi", 32'(phi), 32'(e_phi));
            chk("s1_sync", 32'(sync), 32'((i == 0) || (i == 6)));
            chk("s1_busy", 32'(busy), 32'h1);
            chk("s1_done", 32'(done), 32'h0);
            step();
        end
        chk("s1_end_phi", 32'(phi), 32'h0);
        chk("s1_end_done", 32'(done), 32'h1);
        chk("s1_end_busy", 32'(busy), 32'h0);
        step();
        chk("s1_done_once", 32'(done), 32'h0);

        // START while busy is ignored
        dwell = 4'd0; cycles = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("s6a_phi1", 32'(phi), 32'h1);
        chk("s6a_sync1", 32'(sync), 32'h1);
        step();
        chk("s6a_phi2", 32'(phi), 32'h2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s6a_phi3", 32'(phi), 32'h4);
        chk("s6a_sync3", 32'(sync), 32'h0);
        step();
        chk("s6a_done", 32'(done), 32'h1);
        chk("s6a_phi_idle", 32'(phi), 32'h0);
        step();
        chk("s6a_done_once", 32'(done), 32'h0);

        // START+STOP together in IDLE: start wins, stop dropped
        dwell = 4'd0; cycles = 8'd2; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("s6b_phi1", 32'(phi), 32'h1);
        chk("s6b_busy", 32'(busy), 32'h1);
        step(); step(); step();
        chk("s6b_rot2_phi", 32'(phi), 32'h1);
        chk("s6b_rot2_sync", 32'(sync), 32'h1);
        step(); step();
        chk("s6b_phi6", 32'(phi), 32'h4);
        step();
        chk("s6b_done", 32'(done), 32'h1);
        step();

        // free-running, stop in phase 2 of rotation 4
        dwell = 4'd0; cycles = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("s2_rot4_phi", 32'(phi), 32'h1);
        chk("s2_rot4_sync", 32'(sync), 32'h1);
        step();
        chk("s2_ph2", 32'(phi), 32'h2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s2_ph3", 32'(phi), 32'h4);
        chk("s2_ph3_busy", 32'(busy), 32'h1);
        step();
        chk("s2_idle_phi", 32'(phi), 32'h0);
        chk("s2_done", 32'(done), 32'h1);
        chk("s2_busy", 32'(busy), 32'h0);
        step();
        chk("s2_done_once", 32'(done), 32'h0);
        chk("s2_no_sync", 32'(sync), 32'h0);
        chk("s2_phi_stays", 32'(phi), 32'h0);

        // stop coincides with the final rotation end
        dwell = 4'd1; cycles = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("s3_last_phi", 32'(phi), 32'h4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s3_done", 32'(done), 32'h1);
        chk("s3_busy", 32'(busy), 32'h0);
        chk("s3_phi", 32'(phi), 32'h0);
        step();
        chk("s3_done_once", 32'(done), 32'h0);

        // phase register corrupted to 000
        dwell = 4'd1; cycles = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("s4_pre_phi", 32'(phi), 32'h2);
        chk("s4_pre_err", 32'(err), 32'h0);
        dut.phi_q = 3'b000;
        step();
        chk("s4_z_phi", 32'(phi), 32'h1);
        chk("s4_z_err", 32'(err), 32'h1);
        step();
        chk("s4_z_reload", 32'(phi), 32'h1);
        step();
        chk("s4_z_ph2", 32'(phi), 32'h2);
        step(); step();
        chk("s4_z_ph3", 32'(phi), 32'h4);
        step(); step();
        chk("s4_z_done", 32'(done), 32'h1);
        chk("s4_z_err_held", 32'(err), 32'h1);
        step();
        chk("s4_z_err_idle", 32'(err), 32'h1);

        // phase register corrupted to 011, after ERR cleared by a new start
        dwell = 4'd1; cycles = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("s4_m_err_clr", 32'(err), 32'h0);
        chk("s4_m_phi", 32'(phi), 32'h1);
        dut.phi_q = 3'b011;
        step();
        chk("s4_m_fix_phi", 32'(phi), 32'h1);
        chk("s4_m_err", 32'(err), 32'h1);
        step();

        // reset mid-rotation
        rst = 1'b1;
        step();
        chk("s5_phi", 32'(phi), 32'h0);
        chk("s5_sync", 32'(sync), 32'h0);
        chk("s5_busy", 32'(busy), 32'h0);
        chk("s5_done", 32'(done), 32'h0);
        chk("s5_err", 32'(err), 32'h0);
        rst = 1'b0;
        step();
        chk("s5_post_done", 32'(done), 32'h0);
        chk("s5_post_busy", 32'(busy), 32'h0);

        // reset together with START
        dwell = 4'd0; cycles = 8'd1; rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("s5s_phi", 32'(phi), 32'h0);
        chk("s5s_busy", 32'(busy), 32'h0);
        chk("s5s_sync", 32'(sync), 32'h0);
        chk("s5s_done", 32'(done), 32'h0);
        step();
        chk("s5s_idle_phi", 32'(phi), 32'h0);
        chk("s5s_idle_busy", 32'(busy), 32'h0);
        chk("s5s_idle_done", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL provide parameter NPH, default 3: number of phases, legal range 2..8.
REQ-002 SHALL provide parameter DW, default 4: width of dwell field.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports, one per line, as name  direction  width  meaning:
- CLK_IN  in  1  system clock, all state on rising edge
- RST_IN  in  1  synchronous active-high reset
- START_IN  in  1  start request, sampled only in IDLE
- STOP_IN  in  1  graceful stop request, sampled only in RUN
- DWELL_IN  in  DW  cycles per phase minus 1, latched at start
- CYCLES_IN  in  8  rotations to run, latched at start; 0 = run until stop
- PHI_OUT  out  NPH  one-hot active phase, bit 0 = phase 1; all-zero when idle
- SYNC_OUT  out  1  high during the first cycle of phase 1 of every rotation
- BUSY_OUT  out  1  high in RUN and STOPPING
- DONE_OUT  out  1  one-cycle pulse on return to IDLE
- ERR_OUT  out  1  sticky: illegal phase encoding detected

Function
REQ-005 SHALL have all outputs registered; no combinational path from inputs to outputs.
REQ-006 SHALL implement states IDLE, RUN and STOPPING.
REQ-007 IDLE, START_IN=1 at edge: SHALL go to RUN, latch DWELL_IN/CYCLES_IN, set PHI_OUT=phase 1, SYNC_OUT=1, BUSY_OUT=1, load dwell counter, clear ERR_OUT.
REQ-008 Each phase SHALL last exactly latched DWELL+1 cycles; DWELL=0 gives 1-cycle phases.
REQ-009 At phase end SHALL rotate one-hot left (phase k -> k+1); after phase NPH SHALL wrap to phase 1, increment rotation count, pulse SYNC_OUT.
REQ-010 Rotation counter SHALL be 8 bits; with CYCLES=0 it wraps 255->0 silently and never terminates.
REQ-011 CYCLES!=0: at the end of phase NPH of rotation CYCLES, SHALL go to IDLE with PHI_OUT=0, BUSY_OUT=0 and DONE_OUT=1 for one cycle.
REQ-012 RUN, STOP_IN=1: SHALL go to STOPPING and finish the current rotation through phase NPH, then go to IDLE with DONE_OUT=1.
REQ-013 Stop request and final rotation end on the same edge: SHALL give a single transition to IDLE and exactly one DONE_OUT pulse.
REQ-014 START_IN while BUSY_OUT=1 SHALL be ignored; STOP_IN in IDLE or STOPPING SHALL be ignored.
REQ-015 START_IN and STOP_IN both high in IDLE: SHALL accept the start; the stop in that cycle SHALL be ignored.
REQ-016 Non-one-hot PHI state (zero or multi-bit) in RUN or STOPPING:
- next edge SHALL force phase 1 and reload the dwell counter
- SHALL set ERR_OUT=1, held until reset or the next accepted start
- rotation count SHALL NOT increment
REQ-017 Any undefined FSM encoding SHALL return to IDLE on the next edge.

Reset
REQ-018 RST_IN=1 at an edge SHALL, from any state including mid-rotation, set IDLE, PHI_OUT=0, SYNC_OUT=0, BUSY_OUT=0, DONE_OUT=0, ERR_OUT=0, and clear all counters.
REQ-019 Reset SHALL take priority over START_IN and STOP_IN in the same cycle; no DONE_OUT pulse SHALL result from reset.

Verification
REQ-020 SHALL be covered by these directed scenarios:
- NPH=3, DWELL=1, CYCLES=2, START pulse -> PHI 001,001,010,010,100,100 twice (12 cycles), SYNC at cycles 1 and 7, then PHI=000 with DONE=1 for exactly 1 cycle.
- DWELL=0, CYCLES=0, STOP asserted during phase 2 of rotation 4 -> phases 2,3 complete, then IDLE with one DONE pulse; no further SYNC.
- CYCLES=1, STOP asserted in the last cycle of phase 3 -> single DONE pulse, BUSY falls the same cycle.
- Force PHI state to 000 mid-RUN (separately to 011) -> next cycle PHI=001, ERR=1; ERR clears on next accepted START.
- RST_IN high during RUN, also together with START_IN -> next cycle all outputs 0, state IDLE, no DONE pulse.
- START re-asserted while BUSY, and START+STOP together in IDLE -> first ignored, sequence unaltered; second starts normally.
